// File: rtl/conv1x1_pixel_engine_if.sv
// ---------------------------------------------------------------------------
// conv1x1_pixel_engine_if
// Purpose : bundles the control, pair-stream and result handshakes of the
//           pointwise-conv pixel engine into one interface.
// Signals :
//   start       pulse, begin a new output (latch bias/scale)
//   bias        signed ACC_W-bit bias, sampled on start
//   scale       unsigned Q0.16 requant scale, sampled on start
//   in_valid    weight/activation pair valid
//   in_ready    engine accepts a pair this cycle
//   weight      signed INT8 weight
//   activation  signed INT8 activation
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   out_int8    signed INT8 result
//   busy        engine is not idle
// Modports: master = fetch unit / writer side, slave = engine side.
// ---------------------------------------------------------------------------
interface conv1x1_pixel_engine_if #(
  parameter int ACC_W = 32
);
  logic                    start;
  logic signed [ACC_W-1:0] bias;
  logic [15:0]             scale;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       weight;
  logic signed [7:0]       activation;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_int8;
  logic                    busy;

  modport master (
    output start, bias, scale, in_valid, weight, activation, out_ready,
    input  in_ready, out_valid, out_int8, busy
  );

  modport slave (
    input  start, bias, scale, in_valid, weight, activation, out_ready,
    output in_ready, out_valid, out_int8, busy
  );
endinterface

// File: rtl/conv1x1_pixel_engine.sv
// ---------------------------------------------------------------------------
// conv1x1_pixel_engine
// Purpose : one INT8 output channel of a 1x1 convolution for one pixel.
//           Accumulates NUM_IN_CH weight*activation products, adds the bias,
//           applies LeakyReLU (slope 1/8) and requantizes to INT8 with a
//           round-half-up Q0.SCALE_Q scale and saturation.
// Ports   :
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  conv1x1_pixel_engine_if.slave (start/bias/scale, pair stream,
//        result handshake, busy)
// Build option:
//   ACC_SAT_EN  when defined, the accumulation and the bias add saturate to
//               the signed ACC_W range (sticky for the current output);
//               otherwise both wrap modulo 2^ACC_W. Timing is identical.
// ---------------------------------------------------------------------------
module conv1x1_pixel_engine #(
  parameter int NUM_IN_CH = 128,
  parameter int ACC_W     = 32,
  parameter int SCALE_Q   = 16
) (
  input logic                   clk,
  input logic                   rst,
  conv1x1_pixel_engine_if.slave bus
);

  localparam int P_W   = ACC_W + 17;
  localparam int CNT_W = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1;
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(NUM_IN_CH - 1);
  localparam logic signed [P_W-1:0]  RND      = P_W'(64'd1) << (SCALE_Q - 1);
  localparam logic signed [P_W-1:0]  SAT_HI   = P_W'(64'sd127);
  localparam logic signed [P_W-1:0]  SAT_LO   = P_W'(-64'sd128);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_BIAS  = 3'd2,
    S_LEAKY = 3'd3,
    S_REQ   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] bias_q;
  logic [15:0]             scale_q;
  logic signed [ACC_W-1:0] x_q;
  logic signed [ACC_W-1:0] y_q;
  logic signed [7:0]       out_int8_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic                    busy_q;

  logic signed [15:0]      prod_d;
  logic signed [ACC_W-1:0] prod_ext_d;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] x_d;
  logic signed [ACC_W-1:0] y_d;
  logic signed [P_W-1:0]   p_d;
  logic signed [P_W-1:0]   r_d;
  logic signed [7:0]       q8_d;

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic sat_q;
  logic sat_d;

  // Signed overflow of a + b: the extra sign bit disagrees with the MSB.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    add_ovf = (s[ACC_W] != s[ACC_W-1]);
  endfunction

  // Saturating a + b clamped to the signed ACC_W range.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction
`endif

  // Datapath next values for each pipeline step of the FSM.
  always_comb begin
    prod_d     = bus.weight * bus.activation;
    prod_ext_d = {{(ACC_W-16){prod_d[15]}}, prod_d};
`ifdef ACC_SAT_EN
    // Once clamped, the accumulator stays at the rail for this output.
    sat_d = sat_q;
    if (sat_q) begin
      acc_d = acc_q;
    end else begin
      acc_d = sat_add(acc_q, prod_ext_d);
      sat_d = add_ovf(acc_q, prod_ext_d);
    end
    if (sat_q) begin
      x_d = acc_q;
    end else begin
      x_d = sat_add(acc_q, bias_q);
    end
`else
    acc_d = acc_q + prod_ext_d;
    x_d   = acc_q + bias_q;
`endif
    // LeakyReLU with slope 1/8; arithmetic shift floors negative values.
    if (x_q[ACC_W-1]) begin
      y_d = x_q >>> 2'd3;
    end else begin
      y_d = x_q;
    end
    p_d = P_W'(y_q) * P_W'($signed({1'b0, scale_q}));
    r_d = (p_d + RND) >>> SCALE_Q;
    if (r_d > SAT_HI) begin
      q8_d = 8'sh7F;
    end else if (r_d < SAT_LO) begin
      q8_d = 8'sh80;
    end else begin
      q8_d = r_d[7:0];
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      scale_q     <= 16'd0;
      x_q         <= '0;
      y_q         <= '0;
      out_int8_q  <= 8'sd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= bus.bias;
            scale_q    <= bus.scale;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
`ifdef ACC_SAT_EN
            sat_q      <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCUM: begin
          // in_ready_q is high throughout this state, so in_valid alone accepts.
          if (bus.in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef ACC_SAT_EN
            sat_q <= sat_d;
`endif
            if (cnt_q == LAST_CNT) begin
              in_ready_q <= 1'b0;
              state_q    <= S_BIAS;
            end else begin
              state_q <= S_ACCUM;
            end
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_BIAS: begin
          x_q     <= x_d;
          state_q <= S_LEAKY;
        end
        S_LEAKY: begin
          y_q     <= y_d;
          state_q <= S_REQ;
        end
        S_REQ: begin
          out_int8_q  <= q8_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          // out_int8 is left holding the last result after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_OUT;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_int8  = out_int8_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_conv1x1_pixel_engine.sv
// ---------------------------------------------------------------------------
// tb_conv1x1_pixel_engine
// Directed bench for conv1x1_pixel_engine. Each run pushes its hand-computed
// INT8 result into a queue; a monitor pops and compares on every result
// handshake. Timing, handshake and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_conv1x1_pixel_engine;

  logic clk;
  logic rst;

  conv1x1_pixel_engine_if #(.ACC_W(32)) bus ();

  conv1x1_pixel_engine #(
    .NUM_IN_CH (128),
    .ACC_W     (32),
    .SCALE_Q   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks;
  int n_pass;
  logic signed [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted result is compared against the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", longint'($signed(bus.out_int8)), 1000);
      end else begin
        chk("out_int8", longint'($signed(bus.out_int8)), longint'(exp_q.pop_front()));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [31:0] b, input logic [15:0] sc);
    bus.start = 1'b1;
    bus.bias  = b;
    bus.scale = sc;
    tick();
    bus.start = 1'b0;
  endtask

  // One full output: 128 identical pairs, optional in_valid gaps, optional
  // 5-cycle downstream hold with start pulses during it.
  task automatic run_case(input string nm, input logic signed [31:0] b,
                          input logic [15:0] sc, input logic signed [7:0] w,
                          input logic signed [7:0] a, input logic signed [7:0] expv,
                          input bit gaps, input bit hold);
    bit ready_ok;
    logic ov1, ov2;
    ready_ok      = 1'b1;
    bus.out_ready = !hold;
    do_start(b, sc);
    chk({nm, "_busy"}, longint'(bus.busy), 1);
    exp_q.push_back(expv);
    for (int i = 0; i < 128; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        tick();
        if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      end
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      bus.in_valid   = 1'b1;
      bus.weight     = w;
      bus.activation = a;
      tick();
    end
    chk({nm, "_in_ready_accum"}, longint'(ready_ok), 1);
    // Junk pairs after the last one must not be taken.
    bus.weight     = 8'sd127;
    bus.activation = 8'sd127;
    chk({nm, "_in_ready_after"}, longint'(bus.in_ready), 0);
    tick();
    ov1 = bus.out_valid;
    tick();
    ov2 = bus.out_valid;
    bus.in_valid = 1'b0;
    tick();
    chk({nm, "_latency"}, longint'({ov1, ov2, bus.out_valid}), 1);
    if (!hold) begin
      tick();
      chk({nm, "_out_one_cycle"}, longint'({bus.out_valid, bus.busy}), 0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        chk({nm, "_hold_valid"}, longint'(bus.out_valid), 1);
        chk({nm, "_hold_data"}, longint'($signed(bus.out_int8)), longint'(expv));
        bus.start = 1'b1;
        tick();
      end
      bus.start = 1'b0;
      chk({nm, "_hold_end_valid"}, longint'(bus.out_valid), 1);
      // Release together with a start pulse: the start must be ignored.
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({nm, "_release"}, longint'({bus.out_valid, bus.busy}), 0);
      tick();
      chk({nm, "_start_ignored"}, longint'(bus.busy), 0);
    end
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.bias       = 32'sd0;
    bus.scale      = 16'd0;
    bus.in_valid   = 1'b0;
    bus.weight     = 8'sd0;
    bus.activation = 8'sd0;
    bus.out_ready  = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", longint'({bus.busy, bus.in_ready, bus.out_valid, bus.out_int8}), 0);
    rst = 1'b0;
    tick();

    // Pairs offered while idle must be ignored.
    bus.in_valid   = 1'b1;
    bus.weight     = 8'sd127;
    bus.activation = 8'sd127;
    repeat (3) tick();
    chk("idle_in_ready", longint'({bus.in_ready, bus.busy}), 0);
    bus.in_valid = 1'b0;

    run_case("T1", 32'sd0, 16'd32768, 8'sd1, 8'sd1, 8'sd64, 1'b0, 1'b0);
    run_case("T2", 32'sd0, 16'd32768, -8'sd1, 8'sd1, -8'sd8, 1'b0, 1'b0);
    run_case("T3", 32'sd1000, 16'd65535, 8'sd127, 8'sd127, 8'sd127, 1'b0, 1'b0);
    run_case("T4", 32'sd0, 16'd32768, 8'sd1, 8'sd1, 8'sd64, 1'b1, 1'b0);
    run_case("T5", 32'sd0, 16'd32768, 8'sd1, 8'sd1, 8'sd64, 1'b0, 1'b1);

    // T6: reset after 50 pairs discards the partial output.
    do_start(32'sd0, 16'd32768);
    for (int i = 0; i < 50; i++) begin
      bus.in_valid   = 1'b1;
      bus.weight     = 8'sd5;
      bus.activation = 8'sd5;
      tick();
    end
    chk("T6_busy_before_rst", longint'({bus.busy, bus.in_ready}), 3);
    rst = 1'b1;
    #1;
    chk("T6_rst_outputs", longint'({bus.busy, bus.in_ready, bus.out_valid, bus.out_int8}), 0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_case("T6b", 32'sd0, 16'd32768, -8'sd1, 8'sd1, -8'sd8, 1'b0, 1'b0);

    // x=232, scale 0.25 -> 58.0 + 0.5 floor = 58.
    run_case("T8", 32'sd1000, 16'd16384, 8'sd2, -8'sd3, 8'sd58, 1'b0, 1'b0);
    // x=-1 -> y=-1 -> -65535+32768 >>> 16 = -1.
    run_case("T9", -32'sd1, 16'd65535, 8'sd0, 8'sd5, -8'sd1, 1'b0, 1'b0);
    // x=-2048 -> y=-256 -> about -256 -> saturates to -128.
    run_case("T10", -32'sd2048, 16'd65535, 8'sd0, 8'sd5, -8'sd128, 1'b0, 1'b0);
`ifdef ACC_SAT_EN
    // Bias add clamps at 2^31-1 -> positive saturation.
    run_case("T7", 32'sh7FFF_FF9C, 16'd65535, 8'sd127, 8'sd127, 8'sd127, 1'b0, 1'b0);
`else
    // Bias add wraps to a large negative value -> negative saturation.
    run_case("T7", 32'sh7FFF_FF9C, 16'd65535, 8'sd127, 8'sd127, -8'sd128, 1'b0, 1'b0);
`endif

    repeat (2) tick();
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
